// File: rtl/micro_trace_writer.sv
// rtl/micro_trace_writer.sv - micro core state capture to ASCII vector-line streamer
//
// Snapshots the micro core architectural state into a small FIFO and streams
// each snapshot as one 22-byte lowercase-hex text line
// "pc inst w is_zero a b d\n" over a byte-wide valid/ready interface.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears FIFO, FSM and overflow
//   capture_en  snapshot {pc, inst, w, is_zero, a, b, d} at this edge
//   pc, inst, w, is_zero, a, b, d   micro core state inputs
//   tx_data     current ASCII byte (8'h00 when idle)
//   tx_valid    tx_data is valid; held until accepted
//   tx_ready    sink accepts the byte when tx_valid is also high
//   overflow    sticky; a capture was dropped because the FIFO was full
//   fifo_count  occupied FIFO entries (the in-flight line is not counted)
//   busy        a line is being serialized
module micro_trace_writer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic [7:0]               pc,
  input  logic [12:0]              inst,
  input  logic [7:0]               w,
  input  logic                     is_zero,
  input  logic [7:0]               a,
  input  logic [7:0]               b,
  input  logic [7:0]               d,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = 54;
  localparam logic [4:0]  LAST_IDX = 5'd21;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [4:0]      idx;
  logic [4:0]      idx_next;

  logic [SW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [SW-1:0]   hold;
  logic [SW-1:0]   snap_in;

  logic            fifo_empty;
  logic            fifo_full;
  logic            accept;
  logic            pop;
  logic            push;
  logic            drop;

  logic [7:0]      h_pc;
  logic [12:0]     h_inst;
  logic [7:0]      h_w;
  logic            h_zero;
  logic [7:0]      h_a;
  logic [7:0]      h_b;
  logic [7:0]      h_d;

  logic [3:0]      nib;
  logic            digit;
  logic [7:0]      sep;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign snap_in    = {pc, inst, w, is_zero, a, b, d};
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign accept     = (state == SEND) && tx_ready;

  // A pop frees a slot at the same edge, so a full FIFO still takes the push.
  assign push = capture_en && (!fifo_full || pop);
  assign drop = capture_en && fifo_full && !pop;

  // Next-state logic: the holding register is reloaded straight after the
  // final LF is accepted so back-to-back lines have no bubble cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          idx_next   = 5'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx != LAST_IDX) begin
            idx_next = idx + 5'd1;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            idx_next = 5'd0;
          end else begin
            idx_next   = 5'd0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 5'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array has no reset; occupancy is tracked by the pointers.
  // When full with a simultaneous pop, wr_ptr == rd_ptr: the hold register
  // reads the old entry while the new snapshot overwrites that slot.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= snap_in;
    end
  end

  assign h_pc   = hold[53:46];
  assign h_inst = hold[45:33];
  assign h_w    = hold[32:25];
  assign h_zero = hold[24];
  assign h_a    = hold[23:16];
  assign h_b    = hold[15:8];
  assign h_d    = hold[7:0];

  // Byte layout: 0-1 pc, 3-6 inst (zero-extended to 16 bits), 8-9 w,
  // 11 is_zero, 13-14 a, 16-17 b, 19-20 d, 21 LF, all others SP.
  always_comb begin
    nib   = 4'h0;
    digit = 1'b1;
    sep   = 8'h20;
    case (idx)
      5'd0:    nib = h_pc[7:4];
      5'd1:    nib = h_pc[3:0];
      5'd3:    nib = {3'b000, h_inst[12]};
      5'd4:    nib = h_inst[11:8];
      5'd5:    nib = h_inst[7:4];
      5'd6:    nib = h_inst[3:0];
      5'd8:    nib = h_w[7:4];
      5'd9:    nib = h_w[3:0];
      5'd11:   nib = {3'b000, h_zero};
      5'd13:   nib = h_a[7:4];
      5'd14:   nib = h_a[3:0];
      5'd16:   nib = h_b[7:4];
      5'd17:   nib = h_b[3:0];
      5'd19:   nib = h_d[7:4];
      5'd20:   nib = h_d[3:0];
      5'd21: begin
        digit = 1'b0;
        sep   = 8'h0a;
      end
      default: digit = 1'b0;
    endcase
  end

  assign tx_valid   = (state == SEND);
  assign busy       = (state == SEND);
  assign tx_data    = (state == SEND) ? (digit ? hex_char(nib) : sep) : 8'h00;
  assign fifo_count = count;

endmodule

// File: tb/tb_micro_trace_writer.sv
// tb/tb_micro_trace_writer.sv - self-checking bench for micro_trace_writer
module tb_micro_trace_writer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic [7:0]  pc;
  logic [12:0] inst;
  logic [7:0]  w;
  logic        is_zero;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  d;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic [3:0]  fifo_count;
  logic        busy;

  micro_trace_writer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .pc         (pc),
    .inst       (inst),
    .w          (w),
    .is_zero    (is_zero),
    .a          (a),
    .b          (b),
    .d          (d),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of snapshots plus the text line in flight.
  logic [53:0] mq[$];
  bit          m_send = 0;
  int          m_pos  = 0;
  bit          m_ovf  = 0;
  string       m_line = "";

  function automatic string fmt_line(input logic [53:0] s);
    return $sformatf("%02x %04x %02x %1x %02x %02x %02x\n",
                     s[53:46], {3'b000, s[45:33]}, s[32:25], s[24],
                     s[23:16], s[15:8], s[7:0]);
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    bit pop;
    bit full;
    if (reset) begin
      mq.delete();
      m_send = 0;
      m_pos  = 0;
      m_ovf  = 0;
    end else begin
      acc  = m_send && tx_ready;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && (!m_send || (acc && m_pos == 21));
      if (acc && m_pos < 21) m_pos++;
      else if (acc && m_pos == 21 && !pop) m_send = 0;
      if (pop) begin
        m_line = fmt_line(mq.pop_front());
        m_pos  = 0;
        m_send = 1;
      end
      if (capture_en) begin
        if (!full || pop) mq.push_back({pc, inst, w, is_zero, a, b, d});
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison, byte collection and valid-run tracking.
  logic [7:0] got[$];
  bit         prev_hold = 0;
  logic [7:0] prev_data = 8'h00;
  int         run = 0;
  int         max_run = 0;

  always @(negedge clk) begin
    if (check_en) begin
      check("tx_valid", tx_valid, m_send);
      check("tx_data", tx_data, m_send ? m_line[m_pos] : 8'h00);
      check("busy", busy, m_send);
      check("fifo_count", fifo_count, mq.size());
      check("overflow", overflow, m_ovf);
      if (prev_hold) check("tx_data_stable", tx_data, prev_data);
    end
    prev_hold = tx_valid && !tx_ready && !reset;
    prev_data = tx_data;
    if (tx_valid && tx_ready && !reset) got.push_back(tx_data);
    if (tx_valid) run++;
    else run = 0;
    if (run > max_run) max_run = run;
  end

  logic [7:0] golden [0:21] = '{8'h30, 8'h35, 8'h20, 8'h31, 8'h61, 8'h33, 8'h66, 8'h20,
                                8'h66, 8'h66, 8'h20, 8'h31, 8'h20, 8'h30, 8'h30, 8'h20,
                                8'h37, 8'h63, 8'h20, 8'h31, 8'h30, 8'h0a};
  localparam logic [53:0] GOLD_SNAP = {8'h05, 13'h1a3f, 8'hff, 1'b1, 8'h00, 8'h7c, 8'h10};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [53:0] s);
    {pc, inst, w, is_zero, a, b, d} = s;
  endtask

  task automatic capture(input logic [53:0] s);
    set_inputs(s);
    capture_en = 1;
    step();
    capture_en = 0;
  endtask

  function automatic logic [53:0] rand_snap();
    return {$urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    reset = 1;
    capture_en = 0;
    step();
    step();
    reset = 0;
    got.delete();
    run = 0;
    max_run = 0;
  endtask

  task automatic wait_idle(input int n, input int budget, input bit rnd, input string name);
    int c = 0;
    while ((got.size() < n || busy || fifo_count != 0) && c < budget) begin
      if (rnd) tx_ready = $urandom_range(0, 1);
      step();
      c++;
    end
    tx_ready = 1;
    check({name, "_timeout"}, (c < budget), 1'b1);
  endtask

  task automatic check_golden(input string name);
    check({name, "_len"}, got.size(), 22);
    for (int i = 0; i < 22 && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got[i], golden[i]);
  endtask

  initial begin
    clk = 0; reset = 1; capture_en = 0; tx_ready = 0;
    set_inputs('0);
    step();
    step();
    reset = 0;
    check_en = 1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 1'b0);

    // Single line with first-byte latency.
    do_reset();
    tx_ready = 1;
    capture(GOLD_SNAP);
    check("lat_count_after_capture", fifo_count, 1);
    check("lat_valid_after_capture", tx_valid, 1'b0);
    step();
    check("lat_valid_next_edge", tx_valid, 1'b1);
    check("lat_first_byte", tx_data, 8'h30);
    wait_idle(22, 60, 0, "single");
    check_golden("single");

    // Backpressure.
    do_reset();
    tx_ready = 0;
    capture(GOLD_SNAP);
    wait_idle(22, 400, 1, "bp");
    check_golden("bp");

    // Overflow with tx_ready held low.
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 10; i++) capture({i[7:0], rand_snap()[45:0]});
    check("ovf_fifo_count", fifo_count, 8);
    check("ovf_tx_valid", tx_valid, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    tx_ready = 1;
    wait_idle(198, 400, 0, "ovf");
    repeat (5) step();
    check("ovf_total_bytes", got.size(), 198);
    for (int j = 0; j < 9 && j * 22 + 1 < got.size(); j++) begin
      check($sformatf("ovf_line%0d_pc_hi", j), got[j * 22], 8'h30);
      check($sformatf("ovf_line%0d_pc_lo", j), got[j * 22 + 1], 8'h30 + j[7:0]);
    end
    check("ovf_sticky", overflow, 1'b1);

    // Back-to-back captures.
    do_reset();
    tx_ready = 1;
    for (int i = 0; i < 3; i++) capture(rand_snap());
    wait_idle(66, 120, 0, "b2b");
    check("b2b_bytes", got.size(), 66);
    check("b2b_valid_run", max_run, 66);
    check("b2b_fifo_count", fifo_count, 0);
    check("b2b_busy", busy, 1'b0);

    // Reset mid-line, with a capture at the reset edge that must be ignored.
    do_reset();
    tx_ready = 1;
    capture(rand_snap());
    begin
      int c = 0;
      while (got.size() < 7 && c < 40) begin step(); c++; end
      check("midrst_reach_byte7", (c < 40), 1'b1);
    end
    reset = 1;
    capture_en = 1;
    set_inputs(rand_snap());
    step();
    reset = 0;
    capture_en = 0;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_overflow", overflow, 1'b0);
    got.delete();
    capture(GOLD_SNAP);
    wait_idle(22, 60, 0, "midrst");
    check_golden("midrst");

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      capture_en = ($urandom_range(0, 9) == 0);
      set_inputs(rand_snap());
      tx_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 0;
    capture_en = 0;
    tx_ready = 1;
    got.delete();
    wait_idle(0, 400, 0, "rand_drain");

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_trace_writer.md
# micro_trace_writer

Records the `micro` core's architectural state and streams it out as ASCII test-vector lines, one line per captured cycle, over a byte-wide valid/ready interface. It is the producer for the micro vector-file format: each line is the seven fields pc, inst, w, is_zero, a, b, d in lowercase hex, space-separated and newline-terminated, so the vector-checking bench can parse it with `"%x %x %x %x %x %x %x"`. It sits beside `micro` and feeds a UART or a simulation file sink, and generates golden vectors from a known-good core.

## Interface
- DEPTH, 8, snapshot FIFO entries; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- capture_en  input  1  when high at a rising edge, snapshot the state inputs
- pc  input  8  micro program counter
- inst  input  13  micro current instruction
- w  input  8  micro W register
- is_zero  input  1  micro zero flag
- a  input  8  micro register a
- b  input  8  micro register b
- d  input  8  micro register d
- tx_data  output  8  current ASCII byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  sink accepts the byte at this edge when tx_valid is also high
- overflow  output  1  sticky flag; a capture was dropped because the FIFO was full
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries
- busy  output  1  a line is being serialized

## Operation
- Snapshot: 54 bits, {pc, inst, w, is_zero, a, b, d}.
  - Pushed on every edge with capture_en=1 while the FIFO is not full.
  - A capture into a full FIFO with no pop at the same edge is dropped and sets overflow.
  - Push and pop at the same edge on a full FIFO: push accepted, fifo_count unchanged, overflow not set.
- Line format: exactly 22 bytes.
  - pc: 2 digits; SP; inst: 4 digits (zero-extended to 16 bits); SP; w: 2; SP; is_zero: 1; SP; a: 2; SP; b: 2; SP; d: 2; LF (0x0A).
  - Digits are '0'-'9' (0x30-0x39) and 'a'-'f' (0x61-0x66). SP is 0x20.
  - Most-significant nibble is sent first.
- FSM:
  - IDLE: tx_valid=0. If FIFO not empty, pop the head into the holding register, set char index to 0, go to SEND.
  - SEND: tx_valid=1 and tx_data=char(index).
    - On tx_valid&&tx_ready with index<21: index+1.
    - At index=21 with the FIFO not empty: pop the next entry, index=0, stay in SEND.
    - At index=21 with the FIFO empty: go to IDLE.
- Handshake:
  - Once asserted, tx_valid stays high until the byte is accepted.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - The block never withdraws a byte.
- busy=1 in SEND.
- Captured state is frozen in the FIFO and holding register; later input changes never alter a queued or in-flight line.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, overflow=0, fifo_count=0, busy=0, FSM=IDLE, FIFO empty.
- Latency: capture at edge k with the FIFO empty and FSM in IDLE → fifo_count=1 after edge k; pop at edge k+1; tx_valid=1 after edge k+1.
- Throughput: one byte per cycle with tx_ready held high. Consecutive lines have no bubble cycle, so a sustained rate is 22 cycles per line.
- Capture rate above 1/22 per cycle fills the FIFO. When full, overflow behaviour applies.
- Reset mid-line:
  - After the reset edge, tx_valid=0.
  - The partial line is abandoned, not completed.
  - The FIFO is flushed and overflow is cleared.
  - capture_en at the reset edge is ignored.
- overflow clears only on reset.

## Test plan
- Single line: one capture of pc=8'h05, inst=13'h1a3f, w=8'hff, is_zero=1, a=8'h00, b=8'h7c, d=8'h10, with tx_ready=1.
  - Bytes must be "05 1a3f ff 1 00 7c 10\n": 0x30 0x35 0x20 0x31 0x61 0x33 0x66 0x20 0x66 0x66 0x20 0x31 0x20 0x30 0x30 0x20 0x37 0x63 0x20 0x31 0x30 0x0a.
  - tx_valid must go high after the edge following the capture.
- Backpressure: toggle tx_ready pseudo-randomly.
  - The byte sequence must be identical to the single-line case.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Overflow: DEPTH=8, tx_ready=0, 10 consecutive captures with pc=0..9.
  - fifo_count must be 8 with tx_valid=1 (the pc=0 entry is in the holding register) and overflow=1.
  - After releasing tx_ready, lines for pc=0..8 are emitted, pc=9 is dropped, and no other lines appear.
- Back-to-back: 3 captures on consecutive edges with tx_ready=1.
  - Exactly 66 bytes are emitted with tx_valid continuously high.
  - fifo_count returns to 0 and busy drops after the final LF.
- Reset mid-line: assert reset after byte 7 of a line.
  - tx_valid=0 and fifo_count=0 after the reset edge.
  - A capture after reset produces a complete, correct line.
- Round-trip: capture 50 cycles of a running micro and write the bytes to micro_vectors.txt.
  - The micro vector-checking bench replaying that file against the same program must report zero errors.
